// File: rtl/uart_crc_pkg.sv
// Shared types and CRC-16/CCITT-FALSE helpers for the framed UART receiver.
package uart_crc_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } rx_state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // One byte folded in MSB first, no reflection.
   function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++)
         c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: synchroniser, baud counter and byte FSM.
module uart_rx_byte
   import uart_crc_pkg::*;
#(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_in,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       idle,
   output logic       rx_s
);

   localparam int CW = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

   logic [1:0]    sync;
   logic          rx_prev;
   rx_state_t     state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tick;

   assign rx_s      = sync[1];
   assign byte_data = shreg;
   assign idle      = (state == S_IDLE);
   // START samples at mid-bit, every later state at full bit periods.
   assign tick      = (state == S_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[0], rx_in};
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state)
         S_IDLE:  if (rx_prev && !rx_s) state_nx = S_START;
         S_START: if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (tick && bit_idx == 3'd7) state_nx = S_STOP;
         S_STOP: begin
            if (tick) begin
               state_nx   = S_IDLE;
               byte_valid = rx_s;
               frame_err  = !rx_s;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else if (state == S_IDLE) begin
         cnt     <= '0;
         bit_idx <= '0;
      end else if (tick) begin
         cnt <= '0;
         if (state == S_DATA) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_crc_frame_rx.sv
// Framed UART receiver: payload + 2 CRC bytes, inter-byte timeout, valid/ready output.
// CRC checking is built only when CRC_CHECK_EN is defined; otherwise crc_err is 0.
module uart_crc_frame_rx
   import uart_crc_pkg::*;
#(
   parameter int CLK_FREQ      = 50000000,
   parameter int BAUD_RATE     = 9600,
   parameter int PAYLOAD_BYTES = 1,
   parameter int TIMEOUT_BITS  = 20
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       rx_in,
   output logic [8*PAYLOAD_BYTES-1:0] data_out,
   output logic [15:0]                crc_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       crc_err,
   output logic                       frame_err,
   output logic                       overrun,
   output logic                       busy
);

   localparam int BAUD_DIV  = CLK_FREQ / BAUD_RATE;
   localparam int TO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
   localparam int BCW       = $clog2(PAYLOAD_BYTES + 2);
   localparam int TCW       = $clog2(TO_CYCLES + 1);
   localparam logic [BCW-1:0] CRC_HI_IDX = BCW'(PAYLOAD_BYTES);
   localparam logic [BCW-1:0] LAST_IDX   = BCW'(PAYLOAD_BYTES + 1);
   localparam logic [TCW-1:0] TO_LAST    = TCW'(TO_CYCLES - 1);

   logic [7:0]                    byte_data;
   logic                          byte_valid, byte_ferr, rx_idle, rx_s;
   logic [PAYLOAD_BYTES-1:0][7:0] stage_data;
   logic [7:0]                    crc_hi;
   logic [BCW-1:0]                byte_cnt;
   logic [TCW-1:0]                to_cnt;
   logic [15:0]                   rx_crc;
   logic                          to_run, timeout, calc_err;

   uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_in     (rx_in),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .frame_err (byte_ferr),
      .idle      (rx_idle),
      .rx_s      (rx_s)
   );

   assign rx_crc  = {crc_hi, byte_data};
   assign to_run  = (byte_cnt != '0) && rx_idle && rx_s;
   assign timeout = to_run && (to_cnt == TO_LAST);
   assign busy    = !rx_idle || (byte_cnt != '0);

`ifdef CRC_CHECK_EN
   logic [15:0] crc_acc;

   // Seeding from INIT on byte 0 restarts the CRC for every new frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         crc_acc <= CRC16_INIT;
      else if (byte_valid && byte_cnt < CRC_HI_IDX)
         crc_acc <= crc16_update((byte_cnt == '0) ? CRC16_INIT : crc_acc, byte_data);
   end

   assign calc_err = (crc_acc != rx_crc);
`else
   assign calc_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) to_cnt <= '0;
      else if (to_run && !timeout) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt   <= '0;
         stage_data <= '0;
         crc_hi     <= '0;
      end else if (byte_ferr || timeout) begin
         byte_cnt <= '0;
      end else if (byte_valid) begin
         if (byte_cnt == LAST_IDX) begin
            byte_cnt <= '0;
         end else begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == CRC_HI_IDX) crc_hi <= byte_data;
            for (int i = 0; i < PAYLOAD_BYTES; i++)
               if (byte_cnt == BCW'(i)) stage_data[i] <= byte_data;
         end
      end
   end

   // Output registers: a completed frame loads only if the slot is free or being freed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out  <= '0;
         crc_out   <= '0;
         out_valid <= 1'b0;
         crc_err   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= byte_ferr || timeout;
         overrun   <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (byte_valid && byte_cnt == LAST_IDX) begin
            if (!out_valid || out_ready) begin
               data_out  <= stage_data;
               crc_out   <= rx_crc;
               crc_err   <= calc_err;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_crc_frame_rx.sv
// Directed bench for uart_crc_frame_rx with a frame scoreboard (PAYLOAD_BYTES=9, BAUD_DIV=16).
module tb_uart_crc_frame_rx;

   localparam int BD = 16;
   localparam int P  = 9;
   localparam int TB = 20;

   typedef struct {
      logic [8*P-1:0] data;
      logic [15:0]    crc;
      logic           err;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset_n, rx_in, out_ready;
   logic [8*P-1:0] data_out;
   logic [15:0]    crc_out;
   logic           out_valid, crc_err, frame_err, overrun, busy;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [7:0]  fb[11];
   int          pass_cnt = 0, fail_cnt = 0, total = 0;
   int          ferr_cnt = 0, ovr_cnt = 0;
   int          ferr0, ovr0;
   logic [15:0] crc_tmp;

   uart_crc_frame_rx #(
      .CLK_FREQ(160), .BAUD_RATE(10), .PAYLOAD_BYTES(P), .TIMEOUT_BITS(TB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx_in(rx_in),
      .data_out(data_out), .crc_out(crc_out), .out_valid(out_valid),
      .out_ready(out_ready), .crc_err(crc_err), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference CRC over fb[0..P-1].
   function automatic logic [15:0] model_crc();
      logic [15:0] c = 16'hFFFF;
      logic        fbk;
      for (int i = 0; i < P; i++)
         for (int k = 7; k >= 0; k--) begin
            fbk = c[15] ^ fb[i][k];
            c   = {c[14:0], 1'b0};
            if (fbk) c = c ^ 16'h1021;
         end
      return c;
   endfunction

   task automatic send_byte(input logic [7:0] v, input logic stop);
      rx_in = 1'b0;
      repeat (BD) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx_in = v[k];
         repeat (BD) @(negedge clk);
      end
      rx_in = stop;
      repeat (BD) @(negedge clk);
      rx_in = 1'b1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < P; i++) fb[i] = 8'($urandom);
   endtask

   task automatic send_frame(input logic [15:0] rcv, input bit expect_out);
      exp_t e;
      fb[9]  = rcv[15:8];
      fb[10] = rcv[7:0];
      if (expect_out) begin
         for (int i = 0; i < P; i++) e.data[i*8 +: 8] = fb[i];
         e.crc = rcv;
`ifdef CRC_CHECK_EN
         e.err = (model_crc() != rcv);
`else
         e.err = 1'b0;
`endif
         sb.push_back(e);
      end
      for (int i = 0; i < 11; i++) send_byte(fb[i], 1'b1);
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
      check("drain", 128'(sb.size()), 0);
      repeat (4) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
         check("frame_expected", 128'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("data_out", data_out, mon_e.data);
            check("crc_out", crc_out, mon_e.crc);
            check("crc_err", crc_err, mon_e.err);
         end
      end
   end

   initial begin
      reset_n = 1'b0; rx_in = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", data_out, 0);
      check("rst_crc", crc_out, 0);
      check("rst_valid", out_valid, 0);
      check("rst_crc_err", crc_err, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // Check value "123456789" -> 0x29B1, then a corrupted CRC
      for (int i = 0; i < P; i++) fb[i] = 8'h31 + 8'(i);
      send_frame(16'h29B1, 1'b1);
      wait_drain(100);
      check("byte0", data_out[7:0], 8'h31);
      send_frame(16'h29B0, 1'b1);
      wait_drain(100);

      // Stop bit low on byte 2
      ferr0 = ferr_cnt;
      fill_random();
      send_byte(fb[0], 1'b1);
      send_byte(fb[1], 1'b1);
      send_byte(fb[2], 1'b0);
      repeat (2 * BD) @(negedge clk);
      check("stop_ferr", 128'(ferr_cnt - ferr0), 1);
      check("stop_busy", busy, 0);
      fill_random();
      crc_tmp = model_crc();
      send_frame(crc_tmp, 1'b1);
      wait_drain(100);

      // Short low glitch on the idle line
      ferr0 = ferr_cnt;
      rx_in = 1'b0;
      repeat (BD / 4) @(negedge clk);
      rx_in = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_busy_hi", busy, 1);
      repeat (3 * BD) @(negedge clk);
      check("glitch_busy_lo", busy, 0);
      check("glitch_ferr", 128'(ferr_cnt - ferr0), 0);

      // Inter-byte timeout after one byte
      ferr0 = ferr_cnt;
      fill_random();
      send_byte(fb[0], 1'b1);
      check("partial_busy", busy, 1);
      repeat ((TB + 1) * BD) @(negedge clk);
      check("timeout_ferr", 128'(ferr_cnt - ferr0), 1);
      check("timeout_busy", busy, 0);

      // Overrun: two frames with the consumer stalled
      out_ready = 1'b0;
      ovr0 = ovr_cnt;
      fill_random();
      crc_tmp = model_crc();
      send_frame(crc_tmp, 1'b1);
      fill_random();
      crc_tmp = model_crc();
      send_frame(crc_tmp, 1'b0);
      repeat (4) @(negedge clk);
      check("overrun_pulse", 128'(ovr_cnt - ovr0), 1);
      check("overrun_valid", out_valid, 1);
      check("overrun_hold", data_out, sb[0].data);
      out_ready = 1'b1;
      wait_drain(20);
      check("valid_fall", out_valid, 0);

      // Reset mid-byte
      rx_in = 1'b0;
      repeat (3 * BD) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_data", data_out, 0);
      check("mid_rst_crc", crc_out, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2 * BD) @(negedge clk);
      fill_random();
      crc_tmp = model_crc();
      send_frame(crc_tmp, 1'b1);
      wait_drain(100);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
